// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared defaults and FSM state type for the instruction-memory loader
package loader_pkg;

   localparam int IMEM_DEPTH_DEF = 64;
   localparam int DATA_WIDTH_DEF = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEN   = 3'd1,
      DATA  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream handshake between program source and loader
interface imem_loader_if
   import loader_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/load_counter.sv
// rtl/load_counter.sv - byte-index counter that saturates at the last index of the load
module load_counter
   import loader_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [WIDTH-1:0] last_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o,
   output logic             tc_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] last_q, last_d;

   assign count_o = cnt_q;
   assign tc_o    = (cnt_q == last_q);

   // Restart at index 0 on load; step only while below the terminal index so it never wraps.
   always_comb begin
      cnt_d  = cnt_q;
      last_d = last_q;
      if (load_i) begin
         cnt_d  = '0;
         last_d = last_i;
      end else if (inc_i && !tc_o) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   // Counter and terminal index registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         last_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a length-prefixed, XOR-checked program into instruction memory
module imem_loader
   import loader_pkg::*;
#(
   parameter int  IMEM_DEPTH = IMEM_DEPTH_DEF,
   parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
   localparam int AW         = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_start_i,
   input  logic                  load_abort_i,
   imem_loader_if.slave          in_if,
   output logic                  mem_we_o,
   output logic [AW-1:0]         mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic                  core_run_o,
   output logic                  load_done_o,
   output logic                  load_error_o
);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] csum_q, csum_d;
   logic                  we_q, we_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  run_q, run_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic                  xfer;
   logic                  len_ok;
   logic                  cnt_load, cnt_inc, cnt_tc;
   logic [AW-1:0]         cnt, cnt_last;

   assign in_if.in_ready = (state_q == LEN) || (state_q == DATA) || (state_q == CHECK);
   assign xfer           = in_if.in_valid && in_if.in_ready;
   assign len_ok         = (in_if.in_data != '0) && (32'(in_if.in_data) <= $unsigned(IMEM_DEPTH));
   assign cnt_last       = AW'(in_if.in_data - DATA_WIDTH'(1));

   load_counter #(.WIDTH(AW)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .load_i  (cnt_load),
      .last_i  (cnt_last),
      .inc_i   (cnt_inc),
      .count_o (cnt),
      .tc_o    (cnt_tc)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state, checksum and write-port updates; abort overrides everything including start.
   always_comb begin
      state_d  = state_q;
      csum_d   = csum_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      cnt_load = 1'b0;
      cnt_inc  = 1'b0;
      if (load_abort_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE, ERR: begin
               if (load_start_i) state_d = LEN;
            end
            LEN: begin
               if (xfer) begin
                  if (len_ok) begin
                     state_d  = DATA;
                     csum_d   = '0;
                     cnt_load = 1'b1;
                  end else begin
                     state_d = ERR;
                  end
               end
            end
            DATA: begin
               if (xfer) begin
                  csum_d  = csum_q ^ in_if.in_data;
                  we_d    = 1'b1;
                  addr_d  = cnt;
                  wdata_d = in_if.in_data;
                  if (cnt_tc) state_d = CHECK;
                  else        cnt_inc = 1'b1;
               end
            end
            CHECK: begin
               if (xfer) state_d = (in_if.in_data == csum_q) ? DONE : ERR;
            end
            default: state_d = IDLE;
         endcase
      end
      run_d  = (state_d == DONE);
      done_d = (state_d == DONE);
      err_d  = (state_d == ERR);
   end

   // Registered write port, checksum and status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         csum_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         run_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         csum_q  <= csum_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         run_q   <= run_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign mem_we_o     = we_q;
   assign mem_addr_o   = addr_q;
   assign mem_wdata_o  = wdata_q;
   assign core_run_o   = run_q;
   assign load_done_o  = done_q;
   assign load_error_o = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;
   import loader_pkg::*;

   localparam int DEPTH = 64;
   localparam int DW    = 8;
   localparam int AW    = 6;

   typedef logic [7:0] bq_t[$];

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          load_start = 1'b0;
   logic          load_abort = 1'b0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          core_run, load_done, load_error;

   imem_loader_if #(.DATA_WIDTH(DW)) s_if ();

   imem_loader #(.IMEM_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
      .clk          (clk),
      .reset        (reset),
      .load_start_i (load_start),
      .load_abort_i (load_abort),
      .in_if        (s_if),
      .mem_we_o     (mem_we),
      .mem_addr_o   (mem_addr),
      .mem_wdata_o  (mem_wdata),
      .core_run_o   (core_run),
      .load_done_o  (load_done),
      .load_error_o (load_error)
   );

   always #5 clk = ~clk;

   int         total = 0;
   int         bad = 0;
   int         exp_addr_q[$];
   logic [7:0] exp_data_q[$];
   int         nwr = 0;
   int         wcnt[DEPTH];
   int         last_addr = 0;
   logic [7:0] last_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Expected writes and outcome straight from the load rules: length, N bytes, XOR check byte.
   task automatic plan(input bq_t b, output int outcome);
      int         n;
      logic [7:0] x;
      n       = int'(b[0]);
      outcome = 0;
      x       = '0;
      if (n == 0 || n > DEPTH) begin
         outcome = 2;
      end else begin
         for (int i = 0; i < n && i + 1 < b.size(); i++) begin
            exp_addr_q.push_back(i);
            exp_data_q.push_back(b[i+1]);
            x ^= b[i+1];
         end
         if (b.size() > n + 1) outcome = (b[n+1] == x) ? 1 : 2;
      end
   endtask

   // Write-port scoreboard, sampled 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      if (!reset) begin
         chk("run_eq_done", 32'(core_run), 32'(load_done));
         if (mem_we) begin
            nwr++;
            wcnt[mem_addr]++;
            last_addr = int'(mem_addr);
            last_data = mem_wdata;
            if (exp_addr_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_we: got addr=%0d data=%0h want no write", mem_addr, mem_wdata);
            end else begin
               chk("we_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
               chk("we_data", 32'(mem_wdata), 32'(exp_data_q.pop_front()));
            end
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_we"},    32'(mem_we), 0);
      chk({tag, "_addr"},  32'(mem_addr), 0);
      chk({tag, "_wdata"}, 32'(mem_wdata), 0);
      chk({tag, "_run"},   32'(core_run), 0);
      chk({tag, "_done"},  32'(load_done), 0);
      chk({tag, "_err"},   32'(load_error), 0);
      chk({tag, "_rdy"},   32'(s_if.in_ready), 0);
   endtask

   task automatic start_load(input string tag);
      @(negedge clk);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      chk({tag, "_start_run"},  32'(core_run), 0);
      chk({tag, "_start_done"}, 32'(load_done), 0);
      chk({tag, "_start_err"},  32'(load_error), 0);
   endtask

   task automatic send(input logic [7:0] b, input int gap, input logic st);
      repeat (gap) begin
         @(negedge clk);
         s_if.in_valid = 1'b0;
         load_start    = 1'b0;
      end
      @(negedge clk);
      s_if.in_valid = 1'b1;
      s_if.in_data  = b;
      load_start    = st;
      chk("in_ready", 32'(s_if.in_ready), 1);
      @(posedge clk);
   endtask

   task automatic run_load(input string tag, input bq_t b, input int maxgap, input int start_idx);
      int outcome;
      plan(b, outcome);
      nwr = 0;
      start_load(tag);
      foreach (b[i]) send(b[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, i == start_idx);
      @(negedge clk);
      s_if.in_valid = 1'b0;
      load_start    = 1'b0;
      repeat (2) @(negedge clk);
      chk({tag, "_done"},    32'(load_done), 32'(outcome == 1));
      chk({tag, "_err"},     32'(load_error), 32'(outcome == 2));
      chk({tag, "_run"},     32'(core_run), 32'(outcome == 1));
      chk({tag, "_rdy"},     32'(s_if.in_ready), 0);
      chk({tag, "_pending"}, 32'(exp_addr_q.size()), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      bq_t        v;
      int         oc;
      logic [7:0] x;
      s_if.in_valid = 1'b0;
      s_if.in_data  = '0;

      #1 reset = 1'b1;
      #2 chk_zero("reset");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk_zero("idle");

      // Good three-byte program.
      v = {8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hD0};
      run_load("good3", v, 0, -1);
      chk("good3_nwr", 32'(nwr), 3);
      chk("good3_last_addr", 32'(last_addr), 2);
      chk("good3_last_data", 32'(last_data), 32'h0000_00C3);
      chk("good3_lit_done", 32'(load_done), 1);
      repeat (5) @(negedge clk);
      chk("good3_hold_done", 32'(load_done), 1);
      chk("good3_hold_run", 32'(core_run), 1);

      // Bad checksum.
      v = {8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hD1};
      run_load("badck", v, 0, -1);
      chk("badck_nwr", 32'(nwr), 3);
      chk("badck_lit_err", 32'(load_error), 1);

      // Illegal lengths.
      v = {8'h00};
      run_load("len0", v, 0, -1);
      chk("len0_nwr", 32'(nwr), 0);
      v = {8'h41};
      run_load("len65", v, 0, -1);
      chk("len65_nwr", 32'(nwr), 0);
      chk("len65_lit_err", 32'(load_error), 1);

      // Length 1, with a load_start during DATA that must be ignored.
      v = {8'h01, 8'h5A, 8'h5A};
      run_load("len1", v, 0, 1);
      chk("len1_nwr", 32'(nwr), 1);
      chk("len1_lit_done", 32'(load_done), 1);

      // Full-depth load with random valid gaps.
      foreach (wcnt[i]) wcnt[i] = 0;
      v = {8'd64};
      x = '0;
      for (int i = 0; i < DEPTH; i++) begin
         v.push_back(8'(i * 37 + 5));
         x ^= 8'(i * 37 + 5);
      end
      v.push_back(x);
      run_load("full", v, 2, -1);
      chk("full_nwr", 32'(nwr), 64);
      chk("full_last_addr", 32'(last_addr), 63);
      foreach (wcnt[i]) chk($sformatf("full_wcnt%0d", i), 32'(wcnt[i]), 1);

      // Abort together with start after the second data byte.
      v = {8'h03, 8'hA1, 8'hB2};
      plan(v, oc);
      nwr = 0;
      start_load("abort");
      foreach (v[i]) send(v[i], 0, 1'b0);
      @(negedge clk);
      s_if.in_valid = 1'b0;
      load_abort    = 1'b1;
      load_start    = 1'b1;
      @(negedge clk);
      load_abort = 1'b0;
      load_start = 1'b0;
      chk("abort_run", 32'(core_run), 0);
      chk("abort_done", 32'(load_done), 0);
      chk("abort_err", 32'(load_error), 0);
      chk("abort_rdy", 32'(s_if.in_ready), 0);
      s_if.in_valid = 1'b1;
      s_if.in_data  = 8'hC3;
      repeat (3) @(negedge clk);
      s_if.in_valid = 1'b0;
      chk("abort_nwr", 32'(nwr), 2);
      chk("abort_pending", 32'(exp_addr_q.size()), 0);

      // Abort on the same edge a data byte is accepted: that byte is never written.
      v = {8'h03, 8'hA1};
      plan(v, oc);
      nwr = 0;
      start_load("abxf");
      foreach (v[i]) send(v[i], 0, 1'b0);
      @(negedge clk);
      s_if.in_data = 8'hB2;
      load_abort   = 1'b1;
      @(negedge clk);
      s_if.in_valid = 1'b0;
      load_abort    = 1'b0;
      repeat (3) @(negedge clk);
      chk("abxf_nwr", 32'(nwr), 1);
      chk("abxf_pending", 32'(exp_addr_q.size()), 0);
      chk("abxf_rdy", 32'(s_if.in_ready), 0);

      // Asynchronous reset in the middle of DATA, then a clean load.
      v = {8'h03, 8'hA1, 8'hB2};
      plan(v, oc);
      nwr = 0;
      start_load("rst");
      foreach (v[i]) send(v[i], 0, 1'b0);
      @(negedge clk);
      s_if.in_valid = 1'b0;
      #2 reset = 1'b1;
      #1 chk_zero("async_rst");
      exp_addr_q.delete();
      exp_data_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("post_rst");
      v = {8'h02, 8'h11, 8'h22, 8'h33};
      run_load("after_rst", v, 1, -1);
      chk("after_rst_nwr", 32'(nwr), 2);
      chk("after_rst_last_data", 32'(last_data), 32'h0000_0022);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter IMEM_DEPTH, default 64, number of instruction-memory words to be filled.
REQ-002 Parameter DATA_WIDTH, default 8, opcode/byte width.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load_start  input  1  one-cycle request to begin a program load.
REQ-006 load_abort  input  1  abandon any load in progress.
REQ-007 in_valid  input  1  byte-stream source has data.
REQ-008 in_data  input  DATA_WIDTH  stream byte.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 mem_we  output  1  instruction-memory write strobe.
REQ-011 mem_addr  output  clog2(IMEM_DEPTH)  write address.
REQ-012 mem_wdata  output  DATA_WIDTH  opcode written.
REQ-013 core_run  output  1  releases the fetch counter/core; 0 holds it stopped.
REQ-014 load_done  output  1  last load succeeded.
REQ-015 load_error  output  1  last load failed.

Function
REQ-016 A transfer SHALL occur only on a clk edge where in_valid and in_ready are both 1.
REQ-017 The FSM SHALL have states IDLE, LEN, DATA, CHECK, DONE, ERR.
REQ-018 In IDLE, DONE or ERR, load_start SHALL move to LEN next cycle, clear load_done/load_error, and drive core_run 0.
REQ-019 load_start in LEN, DATA or CHECK SHALL be ignored.
REQ-020 in_ready SHALL be 1 exactly in LEN, DATA and CHECK.
REQ-021 In LEN, the accepted byte is length N; N in 1..IMEM_DEPTH SHALL go to DATA with the address counter at 0 and the checksum at 0; N=0 or N>IMEM_DEPTH SHALL go to ERR.
REQ-022 In DATA, each accepted byte SHALL be XORed into the checksum and produce, one cycle later, a single-cycle mem_we=1 with mem_addr = the byte index (0-based) and mem_wdata = the byte.
REQ-023 After the Nth data byte is accepted, the FSM SHALL go to CHECK; the address counter SHALL never exceed N-1 and SHALL never wrap.
REQ-024 In CHECK, an accepted byte equal to the running XOR SHALL go to DONE; otherwise ERR.
REQ-025 DONE SHALL hold core_run=1 and load_done=1 until load_start, load_abort or reset.
REQ-026 ERR SHALL hold core_run=0 and load_error=1 until load_start, load_abort or reset.
REQ-027 load_abort SHALL move any state to IDLE next cycle (core_run=0, done/error 0), SHALL suppress any pending mem_we, and SHALL take priority over a simultaneous load_start.
REQ-028 Memory words at index ≥ N SHALL not be written; already-written words are not rolled back on ERR or abort.
REQ-029 mem_we, mem_addr, mem_wdata, core_run, load_done, load_error SHALL be registered outputs.

Reset
REQ-030 reset SHALL asynchronously force IDLE, core_run=0, load_done=0, load_error=0, mem_we=0, mem_addr=0, mem_wdata=0, checksum=0, address counter=0.
REQ-031 reset asserted mid-load SHALL discard the load; after release the block waits in IDLE for load_start.

Structure
REQ-032 Package loader_pkg SHALL hold IMEM_DEPTH, DATA_WIDTH defaults and the state enum type.
REQ-033 The byte-index counter with terminal-count flag SHALL be one sub-module, load_counter; the FSM, checksum and write register stay in imem_loader.

Verification
REQ-034 load_start; stream 03,A1,B2,C3,D0 (D0 = A1^B2^C3) -> writes (0,A1),(1,B2),(2,C3), then load_done=1, core_run=1.
REQ-035 Same stream with checksum D1 -> three writes, then load_error=1, core_run=0.
REQ-036 Length byte 00, and separately 41 (65) -> ERR immediately, no mem_we pulse.
REQ-037 Length 40 (64), 64 bytes, in_valid toggled randomly -> addresses 0..63 each written exactly once, no wrap, load_done=1.
REQ-038 load_abort and load_start asserted together after the second data byte -> IDLE, core_run=0, no further writes.
REQ-039 reset pulse during DATA -> all outputs at reset values asynchronously; a following full load completes normally.
